// File: rtl/bfloat_pkg.sv
// rtl/bfloat_pkg.sv - shared bfloat16 types, constants and operand classification
//
// Contents:
//   bf16_t      packed {sign, exp[7:0], man[6:0]}
//   bf_flags_t  packed {nv, of, uf, nx}
//   bf_class_t  packed {zero, inf, nan}
//   bf_classify subnormals are reported as zero (flush-to-zero inputs)
package bfloat_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } bf_flags_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } bf_class_t;

    localparam int          BF16_BIAS = 127;
    localparam logic [15:0] BF16_QNAN = 16'hFFFF;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_NINF = 16'hFF80;

    function automatic bf_class_t bf_classify(input bf16_t x);
        bf_class_t c;
        c.zero = (x.exp == 8'h00);
        c.inf  = (x.exp == 8'hFF) && (x.man == 7'h00);
        c.nan  = (x.exp == 8'hFF) && (x.man != 7'h00);
        return c;
    endfunction

endpackage

// File: rtl/bfloat_round_norm.sv
// rtl/bfloat_round_norm.sv - combinational normalise, RNE round and exception select
//
// Ports:
//   sign_i    result sign
//   exp_i     biased exponent before normalisation, 10-bit signed
//   mant_i    raw 8x8 significand product, in [2^14, 2^16)
//   cls_a_i   class bits of operand a
//   cls_b_i   class bits of operand b
//   res_o     bf16 result
//   flags_o   {nv, of, uf, nx}
module bfloat_round_norm
    import bfloat_pkg::*;
#(
    parameter logic [15:0] QNAN    = BF16_QNAN,
    parameter bit          FTZ_OUT = 1'b1
) (
    input  logic               sign_i,
    input  logic signed [9:0]  exp_i,
    input  logic        [15:0] mant_i,
    input  bf_class_t          cls_a_i,
    input  bf_class_t          cls_b_i,
    output logic        [15:0] res_o,
    output bf_flags_t          flags_o
);

    logic        [6:0] frac;
    logic              rnd_bit;
    logic              sticky;
    logic              round_up;
    logic        [7:0] frac_sum;
    logic signed [9:0] exp_fin;
    logic              invalid;
    logic              any_inf;
    logic              any_zero;

    always_comb begin
        // The product of two 1.x significands lies in [1,4); bit 15 tells
        // which binade it landed in.
        if (mant_i[15]) begin
            frac    = mant_i[14:8];
            rnd_bit = mant_i[7];
            sticky  = |mant_i[6:0];
        end else begin
            frac    = mant_i[13:7];
            rnd_bit = mant_i[6];
            sticky  = |mant_i[5:0];
        end

        round_up = rnd_bit & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {7'b0, round_up};

        // frac_sum[7] means 1.1111111 rounded up to 10.0000000; the
        // wrapped fraction (zero) is already correct, only the exponent moves.
        exp_fin = exp_i
                + (mant_i[15]  ? 10'sd1 : 10'sd0)
                + (frac_sum[7] ? 10'sd1 : 10'sd0);

        invalid  = cls_a_i.nan | cls_b_i.nan
                 | (cls_a_i.inf & cls_b_i.zero)
                 | (cls_a_i.zero & cls_b_i.inf);
        any_inf  = cls_a_i.inf | cls_b_i.inf;
        any_zero = cls_a_i.zero | cls_b_i.zero;

        res_o      = {sign_i, exp_fin[7:0], frac_sum[6:0]};
        flags_o    = '0;
        flags_o.nx = rnd_bit | sticky;

        if (invalid) begin
            res_o      = QNAN;
            flags_o    = '0;
            flags_o.nv = 1'b1;
        end else if (any_inf) begin
            res_o   = sign_i ? BF16_NINF : BF16_PINF;
            flags_o = '0;
        end else if (any_zero) begin
            res_o   = {sign_i, 15'h0000};
            flags_o = '0;
        end else if (exp_fin >= 10'sd255) begin
            res_o      = sign_i ? BF16_NINF : BF16_PINF;
            flags_o    = '0;
            flags_o.of = 1'b1;
            flags_o.nx = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
            // Denormal output is not built; with FTZ_OUT cleared the
            // unflushed (wrapped) bits pass through unchanged.
            res_o      = FTZ_OUT ? {sign_i, 15'h0000}
                                 : {sign_i, exp_fin[7:0], frac_sum[6:0]};
            flags_o    = '0;
            flags_o.uf = 1'b1;
            flags_o.nx = 1'b1;
        end
    end

endmodule

// File: rtl/bfloat_mul_pipe.sv
// rtl/bfloat_mul_pipe.sv - 3-stage pipelined bfloat16 multiplier with valid/ready flow
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a/b valid this cycle
//   in_ready   stage can accept; transfer on in_valid & in_ready
//   a, b       bf16 operands
//   out_valid  p/out_flags valid
//   out_ready  consumer accepts; transfer on out_valid & out_ready
//   p          RNE-rounded bf16 product
//   out_flags  {nv, of, uf, nx}
//
// Stages: S1 classify/unpack, S2 significand multiply, S3 round/except
// (combinational in bfloat_round_norm) captured into the output register.
module bfloat_mul_pipe
    import bfloat_pkg::*;
#(
    parameter logic [15:0] QNAN    = BF16_QNAN,
    parameter bit          FTZ_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic [3:0]  out_flags
);

    bf16_t a_op;
    bf16_t b_op;
    logic  en;

    // Stage 1 registers
    logic              v1_q;
    logic              sign1_q, sign1_d;
    logic signed [9:0] e1_q, e1_d;
    logic        [7:0] ma1_q, ma1_d;
    logic        [7:0] mb1_q, mb1_d;
    bf_class_t         ca1_q, ca1_d;
    bf_class_t         cb1_q, cb1_d;

    // Stage 2 registers
    logic              v2_q;
    logic              sign2_q;
    logic signed [9:0] e2_q;
    logic       [15:0] m2_q, m2_d;
    bf_class_t         ca2_q;
    bf_class_t         cb2_q;

    // Stage 3 (output) registers
    logic              v3_q;
    logic       [15:0] p3_q, p3_d;
    bf_flags_t         f3_q, f3_d;

    assign a_op = a;
    assign b_op = b;

    // One global enable: the whole pipe advances unless a result is stuck
    // at the output. Bubbles travel with the data rather than being squeezed out.
    assign en       = ~v3_q | out_ready;
    assign in_ready = en & ~rst;

    always_comb begin
        sign1_d = a_op.sign ^ b_op.sign;
        e1_d    = $signed({2'b00, a_op.exp}) + $signed({2'b00, b_op.exp})
                - 10'(BF16_BIAS);
        ma1_d   = {1'b1, a_op.man};
        mb1_d   = {1'b1, b_op.man};
        ca1_d   = bf_classify(a_op);
        cb1_d   = bf_classify(b_op);
    end

    assign m2_d = 16'(ma1_q) * 16'(mb1_q);

    bfloat_round_norm #(
        .QNAN    (QNAN),
        .FTZ_OUT (FTZ_OUT)
    ) u_round_norm (
        .sign_i  (sign2_q),
        .exp_i   (e2_q),
        .mant_i  (m2_q),
        .cls_a_i (ca2_q),
        .cls_b_i (cb2_q),
        .res_o   (p3_d),
        .flags_o (f3_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            e1_q    <= '0;
            ma1_q   <= '0;
            mb1_q   <= '0;
            ca1_q   <= '0;
            cb1_q   <= '0;
            v2_q    <= 1'b0;
            sign2_q <= 1'b0;
            e2_q    <= '0;
            m2_q    <= '0;
            ca2_q   <= '0;
            cb2_q   <= '0;
            v3_q    <= 1'b0;
            p3_q    <= '0;
            f3_q    <= '0;
        end else if (en) begin
            v1_q    <= in_valid;
            sign1_q <= sign1_d;
            e1_q    <= e1_d;
            ma1_q   <= ma1_d;
            mb1_q   <= mb1_d;
            ca1_q   <= ca1_d;
            cb1_q   <= cb1_d;
            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            e2_q    <= e1_q;
            m2_q    <= m2_d;
            ca2_q   <= ca1_q;
            cb2_q   <= cb1_q;
            v3_q    <= v2_q;
            p3_q    <= p3_d;
            f3_q    <= f3_d;
        end
    end

    assign out_valid = v3_q;
    assign p         = p3_q;
    assign out_flags = f3_q;

endmodule

// File: tb/tb_bfloat_mul_pipe.sv
// tb/tb_bfloat_mul_pipe.sv - scoreboard bench for bfloat_mul_pipe
module tb_bfloat_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic [3:0]  out_flags;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [19:0] sb[$];

    bit          ordy_mode = 1'b0;
    logic        ordy_val  = 1'b1;
    logic        rnd_ready = 1'b1;

    bit          held_valid = 1'b0;
    logic [15:0] held_p;
    logic [3:0]  held_f;

    bfloat_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    assign out_ready = ordy_mode ? rnd_ready : ordy_val;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Exact-product reference: integer significand product, then generic
    // round-to-nearest-even down to 8 significant bits.
    function automatic logic [19:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int ea, eb, ma, mb, prod, msb, shift, q, rem, half, e_res;
        bit za, zb, ia, ib, na, nb, s, nx;
        logic [7:0] e8;
        logic [6:0] f7;
        ea = int'(x[14:7]);  eb = int'(y[14:7]);
        ma = int'(x[6:0]);   mb = int'(y[6:0]);
        s  = x[15] ^ y[15];
        za = (ea == 0);  zb = (eb == 0);
        ia = (ea == 255) && (ma == 0);  ib = (eb == 255) && (mb == 0);
        na = (ea == 255) && (ma != 0);  nb = (eb == 255) && (mb != 0);
        if (na || nb || (ia && zb) || (za && ib)) return {4'b1000, 16'hFFFF};
        if (ia || ib) return {4'b0000, s, 8'hFF, 7'h00};
        if (za || zb) return {4'b0000, s, 15'h0000};
        prod = (128 + ma) * (128 + mb);
        msb = 0;
        for (int i = 0; i < 17; i++) if (((prod >> i) & 1) == 1) msb = i;
        shift = msb - 7;
        q     = prod >> shift;
        rem   = prod - (q << shift);
        half  = 1 << (shift - 1);
        nx    = (rem != 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        e_res = ea + eb - 254 + (msb - 14) + 127;
        if (q == 256) begin
            q = 128;
            e_res++;
        end
        if (e_res >= 255) return {4'b0101, s, 8'hFF, 7'h00};
        if (e_res <= 0) return {4'b0011, s, 15'h0000};
        e8 = 8'(e_res);
        f7 = 7'(q);
        return {3'b000, nx, s, e8, f7};
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        logic [6:0] m;
        int k;
        k = $urandom_range(0, 19);
        m = 7'($urandom);
        if (k == 0) e = 8'h00;
        else if (k == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) m = 7'h00;
        end
        else if (k == 2) e = 8'($urandom_range(1, 20));
        else if (k == 3) e = 8'($urandom_range(230, 254));
        else e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, m};
    endfunction

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] ep, input logic [3:0] ef);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        a = x;
        b = y;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            sb.push_back({ef, ep});
            acc_cyc = cyc;
            @(posedge clk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic check_latency();
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(cyc - acc_cyc), 32'd3);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer and polices stalls.
    always @(negedge clk) begin
        logic [19:0] exp_r;
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) check("stall_hold", 32'({out_flags, p}), 32'({held_f, held_p}));
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                held_valid = 1'b1;
                held_p     = p;
                held_f     = out_flags;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got p=%h flags=%h, expected no output", p, out_flags);
                end else begin
                    exp_r = sb.pop_front();
                    check("result", 32'({out_flags, p}), 32'(exp_r));
                end
            end
        end
    end

    logic [15:0] da [12] = '{16'h3F80, 16'h3FC0, 16'h3F88, 16'h3F81, 16'h7F80, 16'h7FC0,
                             16'hFF80, 16'h8000, 16'h0040, 16'h7F00, 16'h0080, 16'h8080};
    logic [15:0] db [12] = '{16'h4000, 16'h3FC0, 16'h3F88, 16'h3FC0, 16'h0000, 16'h3F80,
                             16'h4000, 16'h4000, 16'h3F80, 16'h7F00, 16'h0080, 16'h0080};
    logic [15:0] dp [12] = '{16'h4000, 16'h4010, 16'h3F90, 16'h3FC2, 16'hFFFF, 16'hFFFF,
                             16'hFF80, 16'h8000, 16'h0000, 16'h7F80, 16'h0000, 16'h8000};
    logic [3:0]  df [12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h8,
                             4'h0, 4'h0, 4'h0, 4'h5, 4'h3, 4'h3};

    initial begin
        logic [15:0] x, y;
        logic [19:0] r;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_p", 32'(p), 32'd0);
        check("reset_flags", 32'(out_flags), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(16'h3F80, 16'h4000, 16'h4000, 4'h0);
        check_latency();
        drain();

        for (int i = 0; i < 12; i++) send(da[i], db[i], dp[i], df[i]);
        drain();

        // Backpressure: four ops against a consumer that stalls for 5 cycles.
        ordy_val = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(da[i], db[i], dp[i], df[i]);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                ordy_val = 1'b1;
            end
        join
        drain();

        // Asynchronous reset while the pipe is full and stalled.
        ordy_val = 1'b0;
        for (int i = 4; i < 7; i++) send(da[i], db[i], dp[i], df[i]);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        check("rst_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        ordy_val = 1'b1;
        send(16'h3FC0, 16'h3FC0, 16'h4010, 4'h0);
        check_latency();
        drain();

        // Randomised traffic with random consumer backpressure.
        ordy_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            x = rand_bf();
            y = rand_bf();
            r = ref_mul(x, y);
            send(x, y, r[15:0], r[19:16]);
        end
        ordy_mode = 1'b0;
        ordy_val  = 1'b1;
        drain();

        repeat (4) @(posedge clk);
        #1;
        check("final_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
